axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares one AXI4 read master port among NUM_PORTS requesters. Each requester has a simplified AR/R handshake interface.
- Round-robin AR arbitration. ARID carries the requester index; R beats are routed back by RID.
- Per-requester outstanding-burst limit.
- Sits between compute kernels and an AXI buffer/memory port on ap_clk.

Parameters:
- NUM_PORTS, 4, number of requesters (2..16)
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 64, data width
- ID_WIDTH, 2, master ID width; must be >= clog2(NUM_PORTS)
- MAX_OUTSTANDING, 4, max in-flight bursts per requester (1..15)

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  asynchronous active-high reset
- req_araddr  in  NUM_PORTS*ADDR_WIDTH  packed per-requester address
- req_arlen  in  NUM_PORTS*8  burst length-1
- req_arsize  in  NUM_PORTS*3  beat size
- req_arvalid  in  NUM_PORTS  request valid
- req_arready  out  NUM_PORTS  request accepted
- req_rdata  out  DATA_WIDTH  shared read data
- req_rresp  out  2  shared response
- req_rlast  out  1  shared last
- req_rvalid  out  NUM_PORTS  per-requester beat valid
- req_rready  in  NUM_PORTS  per-requester beat ready
- m_araddr/m_arlen/m_arsize  out  ADDR_WIDTH/8/3  master AR payload
- m_arid  out  ID_WIDTH  granted requester index
- m_arvalid  out  1
- m_arready  in  1
- m_rdata  in  DATA_WIDTH
- m_rid  in  ID_WIDTH
- m_rresp  in  2
- m_rlast  in  1
- m_rvalid  in  1
- m_rready  out  1
- rid_error  out  1  sticky: beat received with m_rid >= NUM_PORTS

Behaviour:
- Reset (async, any time):
  - Outputs: m_arvalid=0, req_arready=0, rid_error=0.
  - State: state=IDLE, rr_ptr=0, all outstanding counters=0, AR payload regs=0.
  - In-flight bursts are forgotten. The R path is combinational and resumes routing immediately after reset.
- Eligibility: requester i is eligible when req_arvalid[i]=1 and cnt[i] < MAX_OUTSTANDING.
- AR FSM states: IDLE and OFFER.
- IDLE:
  - If any requester is eligible, grant the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - Same cycle: req_arready[g]=1 (single-cycle pulse, combinational from registered state), and g's payload plus m_arid=g are registered.
  - Next cycle: m_arvalid=1, state=OFFER, rr_ptr=(g+1) mod NUM_PORTS, cnt[g]++.
  - If no requester is eligible, stay in IDLE with all req_arready=0.
- OFFER:
  - m_arvalid and the payload are held stable until m_arready=1.
  - On handshake, m_arvalid drops next cycle and state returns to IDLE.
  - No grant is issued while in OFFER. Peak AR throughput is one burst per 2 cycles; grant-to-m_arvalid latency is 1 cycle.
- R routing (combinational, zero latency):
  - req_rdata/rresp/rlast = m_rdata/rresp/rlast.
  - req_rvalid[i] = m_rvalid & (m_rid==i).
  - m_rready = req_rready[m_rid].
- Illegal ID: if m_rid >= NUM_PORTS, m_rready=1 (beat dropped), all req_rvalid=0, rid_error set until reset, no counter change.
- Counter decrement: cnt[m_rid]-- on m_rvalid & m_rready & m_rlast for a legal ID.
  - Increment and decrement on the same counter in the same cycle: net unchanged.
  - Decrement with cnt=0: saturate at 0 and set rid_error.
- Counters are clog2(MAX_OUTSTANDING+1) bits wide and never exceed MAX_OUTSTANDING.
- Requesters must hold their AR payload stable while req_arvalid=1 and not yet acked.

Test Plan:
- Reset then single request: port 2 asserts arvalid, araddr=0x1000, arlen=3 -> req_arready[2] pulses in cycle 0; m_arvalid=1 in cycle 1 with m_arid=2, m_araddr=0x1000, m_arlen=3; slave returns 4 beats rid=2 -> req_rvalid[2] high on each beat, cnt[2] back to 0 after rlast.
- Fairness: all 4 ports assert arvalid continuously, m_arready=1 -> grant order 0,1,2,3,0,... with one grant every 2 cycles.
- Backpressure: m_arready=0 for 5 cycles after m_arvalid -> payload and m_arid held unchanged, no req_arready pulses, grant on cycle after handshake.
- Outstanding limit: MAX_OUTSTANDING=2, port 1 issues 3 requests with no R returns -> third not granted; rlast beat with rid=1 -> third granted next IDLE cycle.
- R backpressure and simultaneity: rid=3 beat with req_rready[3]=0 -> m_rready=0 and beat held; in the same cycle a grant to port 3 coincides with its rlast handshake -> cnt[3] unchanged.
- Illegal ID and async reset: NUM_PORTS=3, beat with m_rid=3 -> m_rready=1, no req_rvalid, rid_error=1 sticky; assert ap_rst mid-OFFER -> m_arvalid=0 and rid_error=0 immediately (asynchronously).

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master among NUM_PORTS requesters.
// AR is granted one burst per two cycles; R beats are steered back by RID.
module axi_read_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int ID_WIDTH        = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_PORTS*8-1:0]          req_arlen,
    input  logic [NUM_PORTS*3-1:0]          req_arsize,
    input  logic [NUM_PORTS-1:0]            req_arvalid,
    output logic [NUM_PORTS-1:0]            req_arready,
    output logic [DATA_WIDTH-1:0]           req_rdata,
    output logic [1:0]                      req_rresp,
    output logic                            req_rlast,
    output logic [NUM_PORTS-1:0]            req_rvalid,
    input  logic [NUM_PORTS-1:0]            req_rready,
    output logic [ADDR_WIDTH-1:0]           m_araddr,
    output logic [7:0]                      m_arlen,
    output logic [2:0]                      m_arsize,
    output logic [ID_WIDTH-1:0]             m_arid,
    output logic                            m_arvalid,
    input  logic                            m_arready,
    input  logic [DATA_WIDTH-1:0]           m_rdata,
    input  logic [ID_WIDTH-1:0]             m_rid,
    input  logic [1:0]                      m_rresp,
    input  logic                            m_rlast,
    input  logic                            m_rvalid,
    output logic                            m_rready,
    output logic                            rid_error
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        IDLE,
        OFFER
    } state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]           cnt_q [NUM_PORTS];
    logic [CW-1:0]           cnt_d [NUM_PORTS];
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic [2:0]              arsize_q, arsize_d;
    logic [ID_WIDTH-1:0]     arid_q, arid_d;
    logic                    rid_err_q, rid_err_d;

    logic [NUM_PORTS-1:0]    elig;
    logic [NUM_PORTS-1:0]    gnt_oh;
    logic [NUM_PORTS-1:0]    dec;
    logic                    gnt_any;
    logic [PW-1:0]           gnt_idx;
    logic                    rid_legal;
    logic                    rsel_ready;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [7:0]              sel_len;
    logic [2:0]              sel_size;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig[i] = req_arvalid[i] && (cnt_q[i] < CW'(MAX_OUTSTANDING));
        end
    end

    // Two passes: indices at/after rr_ptr first, then the wrapped remainder.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!gnt_any && elig[i] && (PW'(i) >= rr_ptr_q)) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(i);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!gnt_any && elig[i]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(i);
            end
        end
    end

    always_comb begin
        gnt_oh   = '0;
        sel_addr = '0;
        sel_len  = '0;
        sel_size = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            gnt_oh[i] = (state_q == IDLE) && gnt_any && (gnt_idx == PW'(i));
            if (gnt_oh[i]) begin
                sel_addr = req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = req_arlen[i*8 +: 8];
                sel_size = req_arsize[i*3 +: 3];
            end
        end
    end

    // Unknown IDs are sunk (ready forced high) and never reach a requester.
    always_comb begin
        rid_legal  = 1'b0;
        rsel_ready = 1'b1;
        req_rvalid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (m_rid == ID_WIDTH'(i)) begin
                rid_legal     = 1'b1;
                rsel_ready    = req_rready[i];
                req_rvalid[i] = m_rvalid;
            end
        end
    end

    always_comb begin
        dec       = '0;
        rid_err_d = rid_err_q | (m_rvalid & ~rid_legal);
        for (int i = 0; i < NUM_PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
            dec[i]   = m_rvalid && rsel_ready && m_rlast && (m_rid == ID_WIDTH'(i));
            if (gnt_oh[i] && !dec[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (dec[i] && !gnt_oh[i]) begin
                if (cnt_q[i] == '0) begin
                    rid_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        arsize_d = arsize_q;
        arid_d   = arid_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d  = OFFER;
                    rr_ptr_d = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
                    araddr_d = sel_addr;
                    arlen_d  = sel_len;
                    arsize_d = sel_size;
                    arid_d   = ID_WIDTH'(gnt_idx);
                end
            end
            OFFER: begin
                if (m_arready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arid_q    <= '0;
            rid_err_q <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arid_q    <= arid_d;
            rid_err_q <= rid_err_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign req_arready = gnt_oh;
    assign m_arvalid   = (state_q == OFFER);
    assign m_araddr    = araddr_q;
    assign m_arlen     = arlen_q;
    assign m_arsize    = arsize_q;
    assign m_arid      = arid_q;
    assign m_rready    = rsel_ready;
    assign req_rdata   = m_rdata;
    assign req_rresp   = m_rresp;
    assign req_rlast   = m_rlast;
    assign rid_error   = rid_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: 3 requesters, 2-bit IDs,
// two outstanding bursts per requester.
`timescale 1ns/1ps
module tb_axi_read_arbiter;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int MO = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP*AW-1:0]  req_araddr = '0;
    logic [NP*8-1:0]   req_arlen = '0;
    logic [NP*3-1:0]   req_arsize = '0;
    logic [NP-1:0]     req_arvalid = '0;
    logic [NP-1:0]     req_arready;
    logic [DW-1:0]     req_rdata;
    logic [1:0]        req_rresp;
    logic              req_rlast;
    logic [NP-1:0]     req_rvalid;
    logic [NP-1:0]     req_rready = '0;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [IW-1:0]     m_arid;
    logic              m_arvalid;
    logic              m_arready = 1'b0;
    logic [DW-1:0]     m_rdata = '0;
    logic [IW-1:0]     m_rid = '0;
    logic [1:0]        m_rresp = '0;
    logic              m_rlast = 1'b0;
    logic              m_rvalid = 1'b0;
    logic              m_rready;
    logic              rid_error;

    int total = 0;
    int bad = 0;

    axi_read_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
    ) dut (
        .ap_clk(clk), .ap_rst(rst),
        .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arsize(req_arsize), .req_arvalid(req_arvalid),
        .req_arready(req_arready), .req_rdata(req_rdata),
        .req_rresp(req_rresp), .req_rlast(req_rlast),
        .req_rvalid(req_rvalid), .req_rready(req_rready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arid(m_arid), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .rid_error(rid_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [7:0] l);
        req_araddr[p*AW +: AW] = a;
        req_arlen[p*8 +: 8]    = l;
        req_arsize[p*3 +: 3]   = 3'd2;
    endtask

    task automatic drain(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            m_rvalid   = 1'b1;
            m_rid      = IW'(id);
            m_rlast    = 1'b1;
            req_rready = '1;
            tick();
        end
        m_rvalid   = 1'b0;
        m_rlast    = 1'b0;
        req_rready = '0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b want=0", m_arvalid); end
        total++; if (req_arready !== 3'b000) begin bad++; $display("FAIL rst_arready got=%b want=000", req_arready); end
        total++; if (rid_error !== 1'b0) begin bad++; $display("FAIL rst_riderr got=%b want=0", rid_error); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b want=0", m_arvalid); end
    endtask

    task automatic test_single();
        logic [1:0] rr;
        set_port(2, 32'h1000, 8'd3);
        req_arvalid = 3'b100;
        #1;
        total++; if (req_arready !== 3'b100) begin bad++; $display("FAIL single_ack got=%b want=100", req_arready); end
        total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL single_pre got=%b want=0", m_arvalid); end
        tick();
        req_arvalid = 3'b000;
        #1;
        total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", m_arvalid); end
        total++; if (m_arid !== 2'd2) begin bad++; $display("FAIL single_id got=%0d want=2", m_arid); end
        total++; if (m_araddr !== 32'h1000) begin bad++; $display("FAIL single_addr got=%h want=1000", m_araddr); end
        total++; if (m_arlen !== 8'd3) begin bad++; $display("FAIL single_len got=%0d want=3", m_arlen); end
        total++; if (m_arsize !== 3'd2) begin bad++; $display("FAIL single_size got=%0d want=2", m_arsize); end
        total++; if (req_arready !== 3'b000) begin bad++; $display("FAIL single_noack got=%b want=000", req_arready); end
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        #1;
        total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL single_drop got=%b want=0", m_arvalid); end
        for (int b = 0; b < 4; b++) begin
            rr         = b[1:0];
            m_rvalid   = 1'b1;
            m_rid      = 2'd2;
            m_rdata    = 32'hD000 + b;
            m_rresp    = rr;
            m_rlast    = (b == 3);
            req_rready = 3'b100;
            #1;
            total++; if (req_rvalid !== 3'b100) begin bad++; $display("FAIL beat_rvalid b=%0d got=%b want=100", b, req_rvalid); end
            total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL beat_rready b=%0d got=%b want=1", b, m_rready); end
            total++; if (req_rdata !== 32'hD000 + b) begin bad++; $display("FAIL beat_data b=%0d got=%h", b, req_rdata); end
            total++; if (req_rresp !== rr) begin bad++; $display("FAIL beat_resp b=%0d got=%0d want=%0d", b, req_rresp, rr); end
            total++; if (req_rlast !== (b == 3)) begin bad++; $display("FAIL beat_last b=%0d got=%b", b, req_rlast); end
            tick();
        end
        m_rvalid   = 1'b0;
        m_rlast    = 1'b0;
        req_rready = '0;
    endtask

    task automatic test_fairness();
        logic [NP-1:0] e;
        int exp;
        for (int i = 0; i < NP; i++) set_port(i, 32'h100 * (i + 1), 8'(i));
        req_arvalid = 3'b111;
        m_arready   = 1'b1;
        for (int g = 0; g < 6; g++) begin
            exp = g % NP;
            e = '0;
            e[exp] = 1'b1;
            #1;
            total++; if (req_arready !== e) begin bad++; $display("FAIL fair_ack g=%0d got=%b want=%b", g, req_arready, e); end
            tick();
            #1;
            total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL fair_valid g=%0d got=%b want=1", g, m_arvalid); end
            total++; if (m_arid !== IW'(exp)) begin bad++; $display("FAIL fair_id g=%0d got=%0d want=%0d", g, m_arid, exp); end
            total++; if (m_araddr !== 32'h100 * (exp + 1)) begin bad++; $display("FAIL fair_addr g=%0d got=%h", g, m_araddr); end
            total++; if (req_arready !== 3'b000) begin bad++; $display("FAIL fair_gap g=%0d got=%b want=000", g, req_arready); end
            tick();
        end
        #1;
        total++; if (req_arready !== 3'b000) begin bad++; $display("FAIL fair_sat got=%b want=000", req_arready); end
        tick();
        total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL fair_sat_v got=%b want=0", m_arvalid); end
        req_arvalid = '0;
        m_arready   = 1'b0;
        for (int r = 0; r < 2; r++) begin
            drain(0, 1);
            drain(1, 1);
            drain(2, 1);
        end
    endtask

    task automatic test_backpressure();
        set_port(0, 32'hA000, 8'd7);
        set_port(1, 32'hB000, 8'd1);
        req_arvalid = 3'b011;
        m_arready   = 1'b0;
        #1;
        total++; if (req_arready !== 3'b001) begin bad++; $display("FAIL bp_ack got=%b want=001", req_arready); end
        tick();
        req_arvalid = 3'b010;
        set_port(0, 32'hDEAD, 8'd0);
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%b", c, m_arvalid); end
            total++; if (m_arid !== 2'd0) begin bad++; $display("FAIL bp_id c=%0d got=%0d want=0", c, m_arid); end
            total++; if (m_araddr !== 32'hA000) begin bad++; $display("FAIL bp_addr c=%0d got=%h want=a000", c, m_araddr); end
            total++; if (m_arlen !== 8'd7) begin bad++; $display("FAIL bp_len c=%0d got=%0d want=7", c, m_arlen); end
            total++; if (req_arready !== 3'b000) begin bad++; $display("FAIL bp_noack c=%0d got=%b", c, req_arready); end
            tick();
        end
        m_arready = 1'b1;
        tick();
        #1;
        total++; if (req_arready !== 3'b010) begin bad++; $display("FAIL bp_next got=%b want=010", req_arready); end
        total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%b want=0", m_arvalid); end
        tick();
        req_arvalid = '0;
        #1;
        total++; if (m_arid !== 2'd1) begin bad++; $display("FAIL bp_id2 got=%0d want=1", m_arid); end
        total++; if (m_araddr !== 32'hB000) begin bad++; $display("FAIL bp_addr2 got=%h want=b000", m_araddr); end
        tick();
        m_arready = 1'b0;
        drain(0, 1);
        drain(1, 1);
    endtask

    task automatic test_limit();
        set_port(1, 32'hC000, 8'd0);
        req_arvalid = 3'b010;
        m_arready   = 1'b1;
        for (int r = 0; r < 2; r++) begin
            #1;
            total++; if (req_arready !== 3'b010) begin bad++; $display("FAIL lim_ack r=%0d got=%b want=010", r, req_arready); end
            tick();
            #1;
            total++; if (m_arid !== 2'd1) begin bad++; $display("FAIL lim_id r=%0d got=%0d want=1", r, m_arid); end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (req_arready !== 3'b000) begin bad++; $display("FAIL lim_block c=%0d got=%b want=000", c, req_arready); end
            tick();
        end
        m_rvalid   = 1'b1;
        m_rid      = 2'd1;
        m_rlast    = 1'b1;
        req_rready = 3'b010;
        #1;
        total++; if (req_rvalid !== 3'b010) begin bad++; $display("FAIL lim_rvalid got=%b want=010", req_rvalid); end
        total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL lim_rready got=%b want=1", m_rready); end
        total++; if (req_arready !== 3'b000) begin bad++; $display("FAIL lim_same got=%b want=000", req_arready); end
        tick();
        m_rvalid   = 1'b0;
        m_rlast    = 1'b0;
        req_rready = '0;
        #1;
        total++; if (req_arready !== 3'b010) begin bad++; $display("FAIL lim_release got=%b want=010", req_arready); end
        tick();
        req_arvalid = '0;
        #1;
        total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL lim_offer got=%b want=1", m_arvalid); end
        tick();
        m_arready = 1'b0;
        drain(1, 2);
    endtask

    task automatic test_rsim();
        set_port(2, 32'hE000, 8'd0);
        req_arvalid = 3'b100;
        m_arready   = 1'b1;
        #1;
        total++; if (req_arready !== 3'b100) begin bad++; $display("FAIL sim_ack1 got=%b want=100", req_arready); end
        tick();
        m_rvalid   = 1'b1;
        m_rid      = 2'd2;
        m_rlast    = 1'b1;
        req_rready = 3'b000;
        #1;
        total++; if (m_rready !== 1'b0) begin bad++; $display("FAIL sim_hold got=%b want=0", m_rready); end
        total++; if (req_rvalid !== 3'b100) begin bad++; $display("FAIL sim_rvalid got=%b want=100", req_rvalid); end
        total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL sim_offer got=%b want=1", m_arvalid); end
        tick();
        #1;
        total++; if (m_rready !== 1'b0) begin bad++; $display("FAIL sim_hold2 got=%b want=0", m_rready); end
        req_rready = 3'b100;
        #1;
        total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL sim_rel got=%b want=1", m_rready); end
        total++; if (req_arready !== 3'b100) begin bad++; $display("FAIL sim_ack2 got=%b want=100", req_arready); end
        tick();
        m_rvalid   = 1'b0;
        m_rlast    = 1'b0;
        req_rready = '0;
        tick();
        #1;
        total++; if (req_arready !== 3'b100) begin bad++; $display("FAIL sim_ack3 got=%b want=100", req_arready); end
        tick();
        tick();
        #1;
        total++; if (req_arready !== 3'b000) begin bad++; $display("FAIL sim_full got=%b want=000", req_arready); end
        req_arvalid = '0;
        m_arready   = 1'b0;
        tick();
    endtask

    task automatic test_illegal_reset();
        m_rvalid   = 1'b1;
        m_rid      = 2'd3;
        m_rlast    = 1'b1;
        req_rready = 3'b000;
        #1;
        total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL ill_rready got=%b want=1", m_rready); end
        total++; if (req_rvalid !== 3'b000) begin bad++; $display("FAIL ill_rvalid got=%b want=000", req_rvalid); end
        total++; if (rid_error !== 1'b0) begin bad++; $display("FAIL ill_early got=%b want=0", rid_error); end
        tick();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rid    = '0;
        #1;
        total++; if (rid_error !== 1'b1) begin bad++; $display("FAIL ill_set got=%b want=1", rid_error); end
        tick();
        tick();
        total++; if (rid_error !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b want=1", rid_error); end
        set_port(0, 32'hF000, 8'd0);
        req_arvalid = 3'b001;
        #1;
        total++; if (req_arready !== 3'b001) begin bad++; $display("FAIL ar_ack got=%b want=001", req_arready); end
        tick();
        req_arvalid = '0;
        #1;
        total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL ar_offer got=%b want=1", m_arvalid); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL ar_async_v got=%b want=0", m_arvalid); end
        total++; if (rid_error !== 1'b0) begin bad++; $display("FAIL ar_async_e got=%b want=0", rid_error); end
        #2;
        rst = 1'b0;
        tick();
        for (int i = 0; i < NP; i++) set_port(i, 32'h10 * i, 8'd0);
        req_arvalid = 3'b111;
        #1;
        total++; if (req_arready !== 3'b001) begin bad++; $display("FAIL ar_ptr got=%b want=001", req_arready); end
        tick();
        req_arvalid = '0;
        m_arready   = 1'b1;
        #1;
        total++; if (m_arid !== 2'd0) begin bad++; $display("FAIL ar_id got=%0d want=0", m_arid); end
        tick();
        m_arready   = 1'b0;
        req_arvalid = 3'b100;
        #1;
        total++; if (req_arready !== 3'b100) begin bad++; $display("FAIL ar_cnt got=%b want=100", req_arready); end
        tick();
        req_arvalid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_limit();
        test_rsim();
        test_illegal_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
